thermometer_model: RTL and testbench
====================================

# thermometer_model

Behavioural simulation model of a TI TMP125 SPI temperature sensor, used in HVAC thermostat system benches as the sensor device. It holds a room temperature that drifts with ambient conditions and with the heating/cooling demand outputs of the thermostat under test. A bus master reads that temperature as a 16-bit SPI frame. The model is synthesizable-style RTL clocked only by the SPI clock, which benches run free.

## Interface
- TICK_DIV, 1000: SPI clock cycles per thermal update tick (1 s at 1 kHz).
- TEMP_RST, 80: reset temperature, signed, 0.25 °C/LSB (20.0 °C).
- STEP_HVAC, 4: per-tick change while heating or cooling (1.0 °C).
- STEP_AMB, 1: per-tick ambient drift (0.25 °C).
- TEMP_MIN / TEMP_MAX, 0 / 200: saturation limits (0 °C / 50 °C).

Ports:
- i_spi_clk  in  1  sole clock, all logic on rising edge.
- i_rst_n  in  1  asynchronous active-low reset.
- i_spi_cs_n  in  1  chip select, active low.
- i_spi_si  in  1  ignored; read-only device.
- o_spi_so  out  1  serial data, MSB first.
- i_heat  in  1  heating demand.
- i_cool  in  1  cooling demand.
- i_amb_hc  in  1  ambient direction: 1 = ambient heats room, 0 = ambient cools room.

## Operation
- temp_q: 10-bit signed, 0.25 °C/LSB, reset TEMP_RST.
- tick counter 0..TICK_DIV-1 runs continuously, independent of CS; tick when it wraps.
- On tick: delta = hvac + amb; hvac = +STEP_HVAC if heat only, -STEP_HVAC if cool only, 0 if neither or both; amb = +STEP_AMB if i_amb_hc else -STEP_AMB.
- Sum computed at 12 bits, then clamped to [TEMP_MIN, TEMP_MAX].
- Frame layout: bit15 = 0, bits14:5 = temp_q, bits4:0 = 0. For example, 20.0 °C gives 0x0A00.
- While cs_n is high, shift register sr reloads the frame every cycle.
- While cs_n is low, sr shifts left, filling with 0, each rising edge. The frame is therefore frozen from the last edge before select, so no tearing.
- o_spi_so = sr[15] combinationally while cs_n is low; 0 while high (see Configuration).
- More than 16 clocks in a frame: the master reads 0s.
- Early deselect aborts the frame; the next select restarts at bit 15.

## Timing
- Master lowers cs_n after rising edge k.
- Bit 15 is valid immediately after cs_n falls and is sampled at edge k+1.
- Bit (15-n) is sampled at edge k+1+n.
- The DUT shifts on the same edge the master samples.
- Reset: temp_q = TEMP_RST, tick counter = 0, sr = frame(TEMP_RST), o_spi_so = 0 (Z with macro).
- Reset mid-frame aborts the frame and reloads sr.
- A tick during an active frame updates temp_q only; the next frame shows the new value.
- First tick occurs TICK_DIV clocks after reset release.

## Configuration
- THERM_SO_TRISTATE_EN defined: o_spi_so is high-impedance while cs_n is high or in reset, allowing a shared bus.
- Undefined: o_spi_so drives 0 while deselected.

## Structure
- Package thermometer_pkg holds:
  - temperature width (10), frame width (16);
  - the frame-packing function;
  - default step/limit constants.
- One sub-module, tmp125_spi_tx: 16-bit load/shift register plus output gating.
- Temperature integrator and tick counter stay in thermometer_model.

## Test plan
- Reset, 5 ms idle, read frame → 0x0A00 (temp 80).
- Heat=0, cool=0, amb_hc=0; read, wait 1 s, read → 0x0A00 then 0x09E0 (79).
- Heat=1, amb_hc=1, wait 3 ticks → temp 95, frame 0x0BE0; heat=1 and cool=1, amb_hc=0, one tick → 94.
- Cool=1, amb_hc=0, run 60 ticks → saturates at 0, frame 0x0000; heat=1, amb_hc=1 for 60 ticks → clamps at 200 (0x1900).
- Abort after 5 bits by raising cs_n, then reselect → full 0x0A00 from bit 15; 20 clocks selected → bits 16–19 read 0.
- Assert i_rst_n low mid-frame → o_spi_so = 0 (Z with THERM_SO_TRISTATE_EN); next frame 0x0A00.

Source files
------------

// File: rtl/thermometer_pkg.sv
// thermometer_pkg: shared widths, default constants and frame packing for the TMP125 model.
package thermometer_pkg;
    localparam int TEMP_W        = 10;
    localparam int FRAME_W       = 16;
    localparam int SUM_W         = 12;
    localparam int TICK_DIV_DEF  = 1000;
    localparam int TEMP_RST_DEF  = 80;
    localparam int STEP_HVAC_DEF = 4;
    localparam int STEP_AMB_DEF  = 1;
    localparam int TEMP_MIN_DEF  = 0;
    localparam int TEMP_MAX_DEF  = 200;

    typedef logic signed [TEMP_W-1:0] temp_t;

    function automatic logic [FRAME_W-1:0] pack_frame(input temp_t t);
        return {1'b0, t, 5'b0};
    endfunction
endpackage

// File: rtl/tmp125_spi_tx.sv
// tmp125_spi_tx: 16-bit load/shift register with gated serial output.
// THERM_SO_TRISTATE_EN: release o_so to Z while deselected or in reset.
module tmp125_spi_tx
    import thermometer_pkg::*;
#(
    parameter logic [FRAME_W-1:0] RST_FRAME = '0
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_cs_n,
    input  logic [FRAME_W-1:0] i_frame,
    output logic               o_so
);
    logic [FRAME_W-1:0] sr_q, sr_d;

    // Reloading on every deselected edge freezes the frame at the last edge before select.
    always_comb sr_d = i_cs_n ? i_frame : {sr_q[FRAME_W-2:0], 1'b0};

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) sr_q <= RST_FRAME;
        else          sr_q <= sr_d;
    end

`ifdef THERM_SO_TRISTATE_EN
    assign o_so = (!i_rst_n || i_cs_n) ? 1'bz : sr_q[FRAME_W-1];
`else
    assign o_so = (!i_rst_n || i_cs_n) ? 1'b0 : sr_q[FRAME_W-1];
`endif
endmodule

// File: rtl/thermometer_model.sv
// thermometer_model: TMP125-style SPI temperature sensor with HVAC/ambient thermal drift.
// THERM_SO_TRISTATE_EN: serial output is high-impedance while deselected or in reset.
module thermometer_model
    import thermometer_pkg::*;
#(
    parameter int TICK_DIV  = TICK_DIV_DEF,
    parameter int TEMP_RST  = TEMP_RST_DEF,
    parameter int STEP_HVAC = STEP_HVAC_DEF,
    parameter int STEP_AMB  = STEP_AMB_DEF,
    parameter int TEMP_MIN  = TEMP_MIN_DEF,
    parameter int TEMP_MAX  = TEMP_MAX_DEF
) (
    input  logic i_spi_clk,
    input  logic i_rst_n,
    input  logic i_spi_cs_n,
    input  logic i_spi_si,
    output logic o_spi_so,
    input  logic i_heat,
    input  logic i_cool,
    input  logic i_amb_hc
);
    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TICK_DIV - 1);
    localparam logic signed [SUM_W-1:0] MIN_S  = SUM_W'(TEMP_MIN);
    localparam logic signed [SUM_W-1:0] MAX_S  = SUM_W'(TEMP_MAX);
    localparam logic signed [SUM_W-1:0] HVAC_S = SUM_W'(STEP_HVAC);
    localparam logic signed [SUM_W-1:0] AMB_S  = SUM_W'(STEP_AMB);

    logic [CW-1:0]           cnt_q, cnt_d;
    temp_t                   temp_q, temp_d;
    logic                    tick;
    logic signed [SUM_W-1:0] hvac, amb, sum;
    logic                    unused_si;

    assign unused_si = i_spi_si;

    always_comb begin
        tick   = (cnt_q == CNT_LAST);
        cnt_d  = tick ? '0 : cnt_q + 1'b1;
        hvac   = (i_heat && !i_cool) ? HVAC_S : (i_cool && !i_heat) ? -HVAC_S : '0;
        amb    = i_amb_hc ? AMB_S : -AMB_S;
        sum    = {{(SUM_W-TEMP_W){temp_q[TEMP_W-1]}}, temp_q} + hvac + amb;
        temp_d = !tick ? temp_q : (sum < MIN_S) ? temp_t'(TEMP_MIN) :
                 (sum > MAX_S) ? temp_t'(TEMP_MAX) : sum[TEMP_W-1:0];
    end

    always_ff @(posedge i_spi_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt_q  <= '0;
            temp_q <= temp_t'(TEMP_RST);
        end else begin
            cnt_q  <= cnt_d;
            temp_q <= temp_d;
        end
    end

    tmp125_spi_tx #(
        .RST_FRAME(pack_frame(temp_t'(TEMP_RST)))
    ) u_tx (
        .i_clk   (i_spi_clk),
        .i_rst_n (i_rst_n),
        .i_cs_n  (i_spi_cs_n),
        .i_frame (pack_frame(temp_q)),
        .o_so    (o_spi_so)
    );
endmodule

// File: tb/tb_thermometer_model.sv
// tb_thermometer_model: scoreboard bench for the TMP125 sensor model (short tick divider).
module tb_thermometer_model;
    localparam int TD = 50;

    logic clk = 1'b0, rst_n = 1'b0, cs_n = 1'b1, si = 1'b0;
    logic heat = 1'b0, cool = 1'b0, amb = 1'b0;
    wire  so;
    int   passed = 0, total = 0;
    int   cnt_m, temp_m;
    logic [15:0] exp_q[$];
    logic [15:0] got;
`ifdef THERM_SO_TRISTATE_EN
    localparam logic SO_IDLE = 1'bz;
`else
    localparam logic SO_IDLE = 1'b0;
`endif

    thermometer_model #(.TICK_DIV(TD)) dut (
        .i_spi_clk  (clk),
        .i_rst_n    (rst_n),
        .i_spi_cs_n (cs_n),
        .i_spi_si   (si),
        .o_spi_so   (so),
        .i_heat     (heat),
        .i_cool     (cool),
        .i_amb_hc   (amb)
    );

    always #5 clk = ~clk;

    // Reference thermal model built from the sensor's update rule.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_m  <= 0;
            temp_m <= 80;
        end else if (cnt_m == TD - 1) begin
            int d;
            d = (heat && !cool) ? 4 : (cool && !heat) ? -4 : 0;
            d = d + (amb ? 1 : -1);
            cnt_m  <= 0;
            temp_m <= (temp_m + d < 0) ? 0 : (temp_m + d > 200) ? 200 : temp_m + d;
        end else begin
            cnt_m <= cnt_m + 1;
        end
    end

    task automatic do_reset(input logic h, input logic c, input logic a);
        rst_n = 1'b0; cs_n = 1'b1; heat = h; cool = c; amb = a;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic wait_ticks(input int n);
        for (int t = 0; t < n; t++) begin
            int guard;
            guard = 0;
            do begin
                @(posedge clk); #1;
                guard++;
            end while (cnt_m != 0 && guard <= TD + 1);
            total++;
            if (guard > TD + 1) $display("FAIL tick_timeout: waited %0d cycles, limit %0d", guard, TD + 1);
            else passed++;
        end
    endtask

    task automatic read_frame(input int nbits, input string name, input logic [15:0] cst, output logic [15:0] w);
        logic [15:0] e;
        logic b;
        @(negedge clk);
        exp_q.push_back(16'(temp_m << 5));
        @(posedge clk); #1 cs_n = 1'b0;
        w = '0;
        for (int i = 0; i < nbits; i++) begin
            @(negedge clk);
            b = so;
            if (i < 16) w = {w[14:0], b};
            else begin
                total++;
                if (b !== 1'b0) $display("FAIL %s_extra_bit%0d: got %b expected 0", name, i, b);
                else passed++;
            end
            @(posedge clk); #1;
        end
        cs_n = 1'b1;
        e = exp_q.pop_front();
        total++;
        if (w !== e) $display("FAIL %s_model: got %h expected %h", name, w, e);
        else passed++;
        total++;
        if (w !== cst) $display("FAIL %s_const: got %h expected %h", name, w, cst);
        else passed++;
    endtask

    task automatic test_reset();
        do_reset(1'b0, 1'b0, 1'b0);
        @(negedge clk);
        total++;
        if (so !== SO_IDLE) $display("FAIL reset_so_idle: got %b expected %b", so, SO_IDLE);
        else passed++;
        repeat (5) @(posedge clk);
        #1 read_frame(16, "reset_read", 16'h0A00, got);
    endtask

    task automatic test_drift();
        wait_ticks(1);
        read_frame(16, "amb_cool", 16'h09E0, got);
    endtask

    task automatic test_heat();
        do_reset(1'b1, 1'b0, 1'b1);
        wait_ticks(3);
        read_frame(16, "heat_3", 16'h0BE0, got);
        heat = 1'b1; cool = 1'b1; amb = 1'b0;
        wait_ticks(1);
        read_frame(16, "heat_cool", 16'h0BC0, got);
    endtask

    task automatic test_saturate();
        heat = 1'b0; cool = 1'b1; amb = 1'b0;
        wait_ticks(60);
        read_frame(16, "sat_min", 16'h0000, got);
        heat = 1'b1; cool = 1'b0; amb = 1'b1;
        wait_ticks(60);
        read_frame(16, "sat_max", 16'h1900, got);
    endtask

    task automatic test_abort();
        logic [4:0] part;
        logic [15:0] e;
        do_reset(1'b0, 1'b0, 1'b1);
        @(negedge clk);
        exp_q.push_back(16'(temp_m << 5));
        @(posedge clk); #1 cs_n = 1'b0;
        part = '0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            part = {part[3:0], so};
            @(posedge clk); #1;
        end
        cs_n = 1'b1;
        e = exp_q.pop_front();
        total++;
        if (part !== e[15:11]) $display("FAIL abort_partial: got %b expected %b", part, e[15:11]);
        else passed++;
        @(posedge clk); #1;
        read_frame(20, "reselect", 16'h0A00, got);
    endtask

    task automatic test_reset_midframe();
        do_reset(1'b1, 1'b0, 1'b1);
        @(posedge clk); #1 cs_n = 1'b0;
        repeat (6) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        total++;
        if (so !== SO_IDLE) $display("FAIL rst_midframe_so: got %b expected %b", so, SO_IDLE);
        else passed++;
        cs_n = 1'b1;
        @(posedge clk); #1 rst_n = 1'b1;
        read_frame(16, "after_rst", 16'h0A00, got);
    endtask

    initial begin
        test_reset();
        test_drift();
        test_heat();
        test_saturate();
        test_abort();
        test_reset_midframe();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
